// File: rtl/countdown_ctrl.sv
// countdown_ctrl: push-button front-end and expiry watcher for the minutes/seconds
// countdown timer. Buttons are synchronised and edge-detected, a BCD minute preset is
// edited in IDLE, and a five-state FSM drives cnt_en/load/alarm/running (all registered).
// Optional build macro COUNTDOWN_ALARM_TIMEOUT_EN: alarm self-clears after ALARM_CYCLES.
module countdown_ctrl #(
    parameter logic [7:0]  MIN_DEFAULT  = 8'h05,
    parameter int unsigned ALARM_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [7:0] xq,
    input  logic [7:0] xh,
    output logic       cnt_en,
    output logic       load,
    output logic [7:0] min_Init,
    output logic       alarm,
    output logic       running
);

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StPause, StDone} state_e;

    state_e     state_q, state_d;
    logic [7:0] min_set_q, min_set_d;
    logic [2:0] sync1_q, sync2_q, prev_q;
    logic [2:0] btn_ev;
    logic       start_ev, up_ev, down_ev, time_zero;
    logic       cnt_en_q, load_q, alarm_q, running_q;

    // BCD +1 with 99 -> 00 wrap
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // BCD -1 with 00 -> 99 wrap
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) begin
            r[3:0] = 4'd9;
            r[7:4] = (v[7:4] == 4'd0) ? 4'd9 : v[7:4] - 4'd1;
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    // Two-flop synchroniser plus previous-value flop for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            prev_q  <= 3'b000;
        end else begin
            sync1_q <= {btn_down, btn_up, btn_start};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign btn_ev    = sync2_q & ~prev_q;
    assign start_ev  = btn_ev[0];
    assign up_ev     = btn_ev[1];
    assign down_ev   = btn_ev[2];
    assign time_zero = (xq == 8'h00) && (xh == 8'h00);

`ifdef COUNTDOWN_ALARM_TIMEOUT_EN
    localparam int unsigned AlarmCntW = (ALARM_CYCLES > 0) ? $clog2(ALARM_CYCLES + 1) : 1;
    logic [AlarmCntW-1:0] alarm_cnt_q, alarm_cnt_d;

    // Alarm duration counter, loaded on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_cnt_q <= '0;
        end else begin
            alarm_cnt_q <= alarm_cnt_d;
        end
    end
`else
    logic unused_alarm_cycles;
    assign unused_alarm_cycles = |ALARM_CYCLES;
`endif

    // Next-state logic for the FSM and the minute preset
    always_comb begin
        state_d   = state_q;
        min_set_d = min_set_q;
`ifdef COUNTDOWN_ALARM_TIMEOUT_EN
        alarm_cnt_d = alarm_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Simultaneous up and down cancel out
                if (up_ev && !down_ev) begin
                    min_set_d = bcd_inc(min_set_q);
                end else if (down_ev && !up_ev) begin
                    min_set_d = bcd_dec(min_set_q);
                end
                if (start_ev) begin
                    state_d = StLoad;
                end
            end
            StLoad: state_d = StRun;
            StRun: begin
                // Expiry beats a coincident start press
                if (time_zero) begin
                    state_d = StDone;
`ifdef COUNTDOWN_ALARM_TIMEOUT_EN
                    alarm_cnt_d = AlarmCntW'(ALARM_CYCLES);
`endif
                end else if (start_ev) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (start_ev) begin
                    state_d = StRun;
                end
            end
            StDone: begin
                if (start_ev) begin
                    state_d = StIdle;
`ifdef COUNTDOWN_ALARM_TIMEOUT_EN
                end else if (alarm_cnt_q <= AlarmCntW'(1)) begin
                    state_d = StIdle;
                end else begin
                    alarm_cnt_d = alarm_cnt_q - AlarmCntW'(1);
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, preset and registered outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            min_set_q <= MIN_DEFAULT;
            cnt_en_q  <= 1'b0;
            load_q    <= 1'b0;
            alarm_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_set_q <= min_set_d;
            cnt_en_q  <= (state_d == StRun);
            load_q    <= (state_d == StLoad);
            alarm_q   <= (state_d == StDone);
            running_q <= (state_d == StRun);
        end
    end

    assign cnt_en   = cnt_en_q;
    assign load     = load_q;
    assign alarm    = alarm_q;
    assign running  = running_q;
    assign min_Init = min_set_q;

endmodule
